vote_result_reporter: RTL and testbench

Reads the final tallies from the voting machine, decides the winner, and transmits a framed result packet over a UART-style serial line. It sits at the output end of the voting datapath: its inputs take the machine's three 32-bit count outputs and the voting-over strobe, and `o_tx` drives the external display/logging link.

---
 rtl/vote_pkg.sv | 29 ++
 rtl/uart_tx_byte.sv | 74 +++++++
 rtl/vote_result_reporter.sv | 164 ++++++++++++++++
 tb/tb_vote_result_reporter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// Shared types and constants for the vote result reporter: FSM states,
// frame layout constants, candidate codes and frame byte helpers.
package vote_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_COMPARE,
    ST_SEND,
    ST_DONE
  } state_t;

  localparam logic [7:0]  FRAME_HDR   = 8'hA5;
  localparam int unsigned FRAME_BYTES = 15;

  localparam logic [1:0] CAND_NONE = 2'd0;
  localparam logic [1:0] CAND_1    = 2'd1;
  localparam logic [1:0] CAND_2    = 2'd2;
  localparam logic [1:0] CAND_3    = 2'd3;

  function automatic logic [7:0] result_byte(input logic tie, input logic [1:0] winner);
    return {tie, 5'b0, winner};
  endfunction

  function automatic logic [7:0] xor_bytes(input logic [31:0] word);
    return word[31:24] ^ word[23:16] ^ word[15:8] ^ word[7:0];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serializer for one byte, LSB first. o_done is high during the final
// clock of the stop bit so a new byte started then follows with no gap.
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam int unsigned     CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [3:0]       BIT_STOP = 4'd9;

  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_bit;
  logic [7:0]       r_sr;
  logic             r_tx;
  logic             r_busy;
  logic             r_done;
  logic             w_last;

  assign w_last = r_busy && (r_bit == BIT_STOP) && (r_cnt == CNT_LAST);

  // r_bit: 0 = start, 1..8 = data, 9 = stop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_bit  <= '0;
      r_sr   <= '0;
      r_tx   <= 1'b1;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy || w_last) begin
        r_cnt <= '0;
        r_bit <= '0;
        if (i_start) begin
          r_busy <= 1'b1;
          r_tx   <= 1'b0;
          r_sr   <= i_data;
        end else begin
          r_busy <= 1'b0;
          r_tx   <= 1'b1;
        end
      end else if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
        r_bit <= r_bit + 4'd1;
        if (r_bit < 4'd8) begin
          r_tx <= r_sr[0];
          r_sr <= {1'b0, r_sr[7:1]};
        end else begin
          r_tx <= 1'b1;
        end
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
        if ((r_bit == BIT_STOP) && (r_cnt == CNT_PRE)) begin
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_tx   = r_tx;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: rtl/vote_result_reporter.sv
// Captures the final tallies on the voting-over rising edge, decides the
// winner and sends a 15-byte checksummed result frame over the serial line.
module vote_result_reporter #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_voting_over,
  input  logic [31:0] i_count1,
  input  logic [31:0] i_count2,
  input  logic [31:0] i_count3,
  output logic        o_tx,
  output logic        o_busy,
  output logic        o_done,
  output logic [1:0]  o_winner,
  output logic        o_tie
);

  import vote_pkg::*;

  localparam logic [3:0] LAST_BYTE = 4'(FRAME_BYTES - 1);

  state_t      r_state;
  logic        r_vo_prev;
  logic [31:0] r_c1;
  logic [31:0] r_c2;
  logic [31:0] r_c3;
  logic [1:0]  r_winner;
  logic        r_tie;
  logic [7:0]  r_csum;
  logic [3:0]  r_byte_idx;
  logic        r_busy;
  logic        r_done;

  logic [1:0]  w_winner;
  logic        w_tie;
  logic [7:0]  w_csum;
  logic [3:0]  w_sel;
  logic [7:0]  w_byte;
  logic        w_start;
  logic        w_tx_busy;
  logic        w_tx_done;

  // A unique strict maximum wins; any shared maximum is a tie
  always_comb begin
    w_winner = CAND_NONE;
    w_tie    = 1'b1;
    if ((r_c1 > r_c2) && (r_c1 > r_c3)) begin
      w_winner = CAND_1;
      w_tie    = 1'b0;
    end else if ((r_c2 > r_c1) && (r_c2 > r_c3)) begin
      w_winner = CAND_2;
      w_tie    = 1'b0;
    end else if ((r_c3 > r_c1) && (r_c3 > r_c2)) begin
      w_winner = CAND_3;
      w_tie    = 1'b0;
    end
  end

  assign w_csum = FRAME_HDR ^ xor_bytes(r_c1) ^ xor_bytes(r_c2) ^ xor_bytes(r_c3)
                ^ result_byte(w_tie, w_winner);

  // Select the byte to hand to the serializer on the next start
  assign w_sel = (r_state == ST_COMPARE) ? 4'd0 : r_byte_idx + 4'd1;

  always_comb begin
    w_byte = FRAME_HDR;
    case (w_sel)
      4'd1:    w_byte = r_c1[31:24];
      4'd2:    w_byte = r_c1[23:16];
      4'd3:    w_byte = r_c1[15:8];
      4'd4:    w_byte = r_c1[7:0];
      4'd5:    w_byte = r_c2[31:24];
      4'd6:    w_byte = r_c2[23:16];
      4'd7:    w_byte = r_c2[15:8];
      4'd8:    w_byte = r_c2[7:0];
      4'd9:    w_byte = r_c3[31:24];
      4'd10:   w_byte = r_c3[23:16];
      4'd11:   w_byte = r_c3[15:8];
      4'd12:   w_byte = r_c3[7:0];
      4'd13:   w_byte = result_byte(r_tie, r_winner);
      4'd14:   w_byte = r_csum;
      default: w_byte = FRAME_HDR;
    endcase
  end

  assign w_start = (r_state == ST_COMPARE) ||
                   ((r_state == ST_SEND) && w_tx_done && (r_byte_idx != LAST_BYTE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_vo_prev  <= 1'b0;
      r_c1       <= '0;
      r_c2       <= '0;
      r_c3       <= '0;
      r_winner   <= CAND_NONE;
      r_tie      <= 1'b0;
      r_csum     <= '0;
      r_byte_idx <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_vo_prev <= i_voting_over;
      r_done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_voting_over && !r_vo_prev && !w_tx_busy) begin
            r_state <= ST_CAPTURE;
            r_busy  <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          r_c1    <= i_count1;
          r_c2    <= i_count2;
          r_c3    <= i_count3;
          r_state <= ST_COMPARE;
        end
        ST_COMPARE: begin
          r_winner   <= w_winner;
          r_tie      <= w_tie;
          r_csum     <= w_csum;
          r_byte_idx <= '0;
          r_state    <= ST_SEND;
        end
        ST_SEND: begin
          if (w_tx_done) begin
            if (r_byte_idx == LAST_BYTE) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_byte_idx <= r_byte_idx + 4'd1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk    (clk),
    .rst    (rst),
    .i_start(w_start),
    .i_data (w_byte),
    .o_tx   (o_tx),
    .o_busy (w_tx_busy),
    .o_done (w_tx_done)
  );

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_winner = r_winner;
  assign o_tie    = r_tie;

endmodule

// File: tb/tb_vote_result_reporter.sv
// Directed bench for vote_result_reporter: decodes the serial frame and
// checks timing, winner/tie, retrigger immunity and mid-frame reset.
module tb_vote_result_reporter;

  localparam int unsigned CPB        = 16;
  localparam int unsigned FRAME_CLKS = 150 * CPB;
  localparam int unsigned WIN        = FRAME_CLKS + 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        vo;
  logic [31:0] c1, c2, c3;
  logic        o_tx, o_busy, o_done, o_tie;
  logic [1:0]  o_winner;

  int checks = 0;
  int errors = 0;

  logic tx_log [WIN];
  int   busy_cnt, done_cnt, done_idx, first_low;

  typedef struct {
    logic [31:0] c1;
    logic [31:0] c2;
    logic [31:0] c3;
    logic [1:0]  win;
    logic        tie;
    logic [7:0]  csum;
  } vec_t;

  vec_t vecs [7];

  vote_result_reporter #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_voting_over(vo),
    .i_count1     (c1),
    .i_count2     (c2),
    .i_count3     (c3),
    .o_tx         (o_tx),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_winner     (o_winner),
    .o_tie        (o_tie)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Raise voting-over, then log one full frame window sampled on negedges
  task automatic run_frame(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input bit retrig);
    @(negedge clk);
    vo = 1'b0;
    c1 = a; c2 = b; c3 = c;
    @(negedge clk);
    vo = 1'b1;
    busy_cnt = 0; done_cnt = 0; done_idx = -1; first_low = -1;
    for (int i = 0; i < int'(WIN); i++) begin
      @(negedge clk);
      tx_log[i] = o_tx;
      if (o_busy) busy_cnt++;
      if (o_done) begin
        done_cnt++;
        if (done_idx < 0) done_idx = i;
      end
      if (first_low < 0 && !o_tx) first_low = i;
      if (i == 3) begin
        c1 = a ^ 32'h5A5A5A5A; c2 = b ^ 32'hA5A5A5A5; c3 = c ^ 32'h0F0F0F0F;
      end
      if (retrig && i == 500) vo = 1'b0;
      if (retrig && i == 600) vo = 1'b1;
    end
  endtask

  task automatic check_frame(input string name, input vec_t v);
    logic [7:0] exp_b [15];
    logic [9:0] got;
    logic [9:0] exp10;
    exp_b[0] = 8'hA5;
    for (int k = 0; k < 4; k++) begin
      exp_b[1 + k] = v.c1[31 - 8*k -: 8];
      exp_b[5 + k] = v.c2[31 - 8*k -: 8];
      exp_b[9 + k] = v.c3[31 - 8*k -: 8];
    end
    exp_b[13] = {v.tie, 5'b0, v.win};
    exp_b[14] = v.csum;
    check($sformatf("%s first_start_idx", name), 32'(first_low), 32'd2);
    check($sformatf("%s busy_clocks", name), 32'(busy_cnt), 32'(FRAME_CLKS + 2));
    check($sformatf("%s done_pulses", name), 32'(done_cnt), 32'd1);
    check($sformatf("%s done_idx", name), 32'(done_idx), 32'(FRAME_CLKS + 2));
    for (int b = 0; b < 15; b++) begin
      for (int k = 0; k < 10; k++) begin
        got[k] = tx_log[2 + (b*10 + k)*CPB + CPB/2];
      end
      exp10 = {1'b1, exp_b[b], 1'b0};
      check($sformatf("%s byte%0d", name, b), 32'(got), 32'(exp10));
    end
    check($sformatf("%s winner", name), 32'(o_winner), 32'(v.win));
    check($sformatf("%s tie", name), 32'(o_tie), 32'(v.tie));
    check($sformatf("%s idle_tx", name), 32'(o_tx), 32'd1);
  endtask

  int busy_after;
  int done_after;
  vec_t v_rst;

  initial begin
    vecs[0] = '{32'd5, 32'd3, 32'd1, 2'd1, 1'b0, 8'hA3};
    vecs[1] = '{32'd7, 32'd7, 32'd2, 2'd0, 1'b1, 8'h27};
    vecs[2] = '{32'd0, 32'd0, 32'd0, 2'd0, 1'b1, 8'h25};
    vecs[3] = '{32'd0, 32'd0, 32'hFFFFFFFF, 2'd3, 1'b0, 8'hA6};
    vecs[4] = '{32'd2, 32'd9, 32'd4, 2'd2, 1'b0, 8'hA8};
    vecs[5] = '{32'd1, 32'd5, 32'd5, 2'd0, 1'b1, 8'h24};
    vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0, 2'd1, 1'b0, 8'hA5};

    rst = 1'b1; vo = 1'b0; c1 = '0; c2 = '0; c3 = '0;
    repeat (3) @(negedge clk);
    check("reset tx", 32'(o_tx), 32'd1);
    check("reset busy", 32'(o_busy), 32'd0);
    check("reset done", 32'(o_done), 32'd0);
    check("reset winner", 32'(o_winner), 32'd0);
    check("reset tie", 32'(o_tie), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int n = 0; n < 7; n++) begin
      run_frame(vecs[n].c1, vecs[n].c2, vecs[n].c3, 1'b0);
      check_frame($sformatf("vec%0d", n), vecs[n]);
    end

    // Second rising edge during SEND must be ignored and not queued
    run_frame(32'd5, 32'd3, 32'd1, 1'b1);
    check_frame("retrig", vecs[0]);
    busy_after = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (o_busy) busy_after++;
    end
    check("retrig no_queue_busy", 32'(busy_after), 32'd0);

    // Reset in the middle of byte 6 (count2 bits are zero, so line is low)
    @(negedge clk);
    vo = 1'b0; c1 = 32'd1; c2 = 32'd0; c3 = 32'd2;
    @(negedge clk);
    vo = 1'b1;
    repeat (1000) @(negedge clk);
    check("midrst pre_tx_low", 32'(o_tx), 32'd0);
    check("midrst pre_busy", 32'(o_busy), 32'd1);
    #2 rst = 1'b1; vo = 1'b0;
    #1;
    check("midrst tx", 32'(o_tx), 32'd1);
    check("midrst busy", 32'(o_busy), 32'd0);
    check("midrst done", 32'(o_done), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    done_after = 0; busy_after = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (o_done) done_after++;
      if (o_busy) busy_after++;
    end
    check("midrst no_done", 32'(done_after), 32'd0);
    check("midrst stays_idle", 32'(busy_after), 32'd0);
    v_rst = '{32'd1, 32'd0, 32'd2, 2'd3, 1'b0, 8'hA5 ^ 8'h01 ^ 8'h02 ^ 8'h03};
    run_frame(v_rst.c1, v_rst.c2, v_rst.c3, 1'b0);
    check_frame("after_rst", v_rst);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
